// File: rtl/spi_status_frame_tx_if.sv
// rtl/spi_status_frame_tx_if.sv - byte stream between the status frame transmitter and the SPI slave transmitter
interface spi_status_frame_tx_if;
    logic [7:0] spi_tx_byte;
    logic       spi_tx_valid;
    logic [3:0] spi_tx_byte_num;
    logic       spi_tx_ready;

    modport master (
        output spi_tx_byte,
        output spi_tx_valid,
        output spi_tx_byte_num,
        input  spi_tx_ready
    );

    modport slave (
        input  spi_tx_byte,
        input  spi_tx_valid,
        input  spi_tx_byte_num,
        output spi_tx_ready
    );
endinterface

// File: rtl/spi_status_frame_tx.sv
// rtl/spi_status_frame_tx.sv - snapshots FPGA status and serialises it as a 9-byte checksummed SPI frame
module spi_status_frame_tx #(
    parameter logic [7:0] SYNC_BYTE = 8'h5A,
    parameter int         TS_WIDTH  = 28
) (
    input  logic                sysClk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                frame_abort,
    input  logic                cam_id,
    input  logic                busy,
    input  logic                capture_done,
    input  logic                error,
    input  logic [15:0]         trigger_index,
    input  logic [TS_WIDTH-1:0] timestamp,
    spi_status_frame_tx_if.master tx,
    output logic                frame_busy,
    output logic                frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          seq_q;
    logic [3:0]          idx_q;
    logic                valid_q;
    logic                done_q;
    logic [7:0]          chk_q;
    logic                cam_q;
    logic                busy_q;
    logic                cdone_q;
    logic                err_q;
    logic [15:0]         trig_q;
    logic [TS_WIDTH-1:0] ts_q;

    logic [31:0]         ts32;
    logic [7:0]          hdr;
    logic [7:0]          chk_d;
    logic [7:0]          cur_byte;

    // Frame contents are derived from the snapshot only, so live status changes cannot leak in
    always_comb begin
        ts32  = 32'(ts_q);
        hdr   = {seq_q, cam_q, busy_q, cdone_q, err_q};
        chk_d = SYNC_BYTE ^ hdr ^ trig_q[15:8] ^ trig_q[7:0]
              ^ ts32[31:24] ^ ts32[23:16] ^ ts32[15:8] ^ ts32[7:0];
        case (idx_q)
            4'd0:    cur_byte = SYNC_BYTE;
            4'd1:    cur_byte = hdr;
            4'd2:    cur_byte = trig_q[15:8];
            4'd3:    cur_byte = trig_q[7:0];
            4'd4:    cur_byte = ts32[31:24];
            4'd5:    cur_byte = ts32[23:16];
            4'd6:    cur_byte = ts32[15:8];
            4'd7:    cur_byte = ts32[7:0];
            4'd8:    cur_byte = chk_q;
            default: cur_byte = 8'h00;
        endcase
    end

    // Outputs come straight from registers; the byte is forced to zero whenever nothing is offered
    always_comb begin
        tx.spi_tx_byte     = valid_q ? cur_byte : 8'h00;
        tx.spi_tx_valid    = valid_q;
        tx.spi_tx_byte_num = idx_q;
        frame_busy         = (state_q != ST_IDLE);
        frame_done         = done_q;
    end

    // Frame sequencer: snapshot, checksum, then one byte per accepted handshake; abort wins over everything
    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seq_q   <= 4'd0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            chk_q   <= 8'h00;
            cam_q   <= 1'b0;
            busy_q  <= 1'b0;
            cdone_q <= 1'b0;
            err_q   <= 1'b0;
            trig_q  <= 16'h0000;
            ts_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!frame_abort && frame_start) begin
                        cam_q   <= cam_id;
                        busy_q  <= busy;
                        cdone_q <= capture_done;
                        err_q   <= error;
                        trig_q  <= trigger_index;
                        ts_q    <= timestamp;
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (frame_abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        chk_q   <= chk_d;
                        idx_q   <= 4'd0;
                        valid_q <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (frame_abort) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        idx_q   <= 4'd0;
                    end else if (valid_q && tx.spi_tx_ready) begin
                        if (idx_q == 4'd8) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                            idx_q   <= 4'd0;
                            done_q  <= 1'b1;
                            seq_q   <= seq_q + 4'd1;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    idx_q   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_status_frame_tx.sv
// tb/tb_spi_status_frame_tx.sv - randomized self-checking bench for spi_status_frame_tx
module tb_spi_status_frame_tx;

    logic        sysClk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_abort = 1'b0;
    logic        cam_id = 1'b0;
    logic        busy = 1'b0;
    logic        capture_done = 1'b0;
    logic        error = 1'b0;
    logic [15:0] trigger_index = 16'h0;
    logic [27:0] timestamp = 28'h0;
    logic        frame_busy;
    logic        frame_done;

    spi_status_frame_tx_if tx_if ();

    spi_status_frame_tx #(.SYNC_BYTE(8'h5A), .TS_WIDTH(28)) dut (
        .sysClk        (sysClk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .frame_abort   (frame_abort),
        .cam_id        (cam_id),
        .busy          (busy),
        .capture_done  (capture_done),
        .error         (error),
        .trigger_index (trigger_index),
        .timestamp     (timestamp),
        .tx            (tx_if),
        .frame_busy    (frame_busy),
        .frame_done    (frame_done)
    );

    always #5 sysClk = ~sysClk;

    int         checks = 0;
    int         failures = 0;
    int         exp_seq = 0;
    logic [7:0] exp_frame [0:8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic randomize_status();
        cam_id        = 1'($urandom);
        busy          = 1'($urandom);
        capture_done  = 1'($urandom);
        error         = 1'($urandom);
        trigger_index = 16'($urandom);
        timestamp     = 28'($urandom);
    endtask

    // Reference frame built from the layout rules using the current status inputs and model sequence number
    task automatic build_expected();
        logic [31:0] ts32;
        ts32 = 32'(timestamp);
        exp_frame[0] = 8'h5A;
        exp_frame[1] = 8'((exp_seq % 16) * 16 + cam_id * 8 + busy * 4 + capture_done * 2 + error);
        exp_frame[2] = 8'(trigger_index / 256);
        exp_frame[3] = 8'(trigger_index % 256);
        for (int i = 0; i < 4; i++) exp_frame[4 + i] = 8'(ts32 >> (24 - 8 * i));
        exp_frame[8] = 8'h00;
        for (int i = 0; i < 8; i++) exp_frame[8] = exp_frame[8] ^ exp_frame[i];
    endtask

    task automatic launch(input bit fixed);
        if (fixed) begin
            cam_id        = 1'b1;
            busy          = 1'b0;
            capture_done  = 1'b1;
            error         = 1'b0;
            trigger_index = 16'h1234;
            timestamp     = 28'hABCDEF0;
        end else begin
            randomize_status();
        end
        build_expected();
        frame_start = 1'b1;
    endtask

    // mode 0: normal, 1: abort once byte 3 accepted, 2: frame_start during SEND, 3: reset during byte 5
    task automatic send_frame(input bit chained, input bit chain_out, input int stall, input int mode, input bit fixed);
        int k;
        int cyc;
        int stall_left;
        bit ended;
        k = 0;
        cyc = 0;
        ended = 1'b0;
        stall_left = (stall == 0) ? 0 : $urandom_range(0, stall);
        if (!chained) launch(fixed);
        @(negedge sysClk);
        frame_start = 1'b0;
        check("latch_busy", 32'(frame_busy), 32'd1);
        check("latch_valid", 32'(tx_if.spi_tx_valid), 32'd0);
        check("latch_done", 32'(frame_done), 32'd0);
        randomize_status();
        while (!ended) begin
            @(negedge sysClk);
            cyc++;
            if (cyc > 100) begin
                check("frame_timeout", 32'(k), 32'd9);
                ended = 1'b1;
            end else if (k == 9) begin
                check("end_done", 32'(frame_done), 32'd1);
                check("end_valid", 32'(tx_if.spi_tx_valid), 32'd0);
                check("end_busy", 32'(frame_busy), 32'd0);
                exp_seq++;
                ended = 1'b1;
                if (chain_out) launch(1'b0);
            end else begin
                check("valid", 32'(tx_if.spi_tx_valid), 32'd1);
                check("byte", 32'(tx_if.spi_tx_byte), 32'(exp_frame[k]));
                check("byte_num", 32'(tx_if.spi_tx_byte_num), 32'(k));
                check("mid_done", 32'(frame_done), 32'd0);
                if (mode == 1 && k == 4) begin
                    frame_abort = 1'b1;
                    tx_if.spi_tx_ready = 1'b1;
                    frame_start = 1'b1;
                    @(negedge sysClk);
                    frame_abort = 1'b0;
                    frame_start = 1'b0;
                    check("abort_valid", 32'(tx_if.spi_tx_valid), 32'd0);
                    check("abort_done", 32'(frame_done), 32'd0);
                    check("abort_busy", 32'(frame_busy), 32'd0);
                    check("abort_num", 32'(tx_if.spi_tx_byte_num), 32'd0);
                    @(negedge sysClk);
                    check("abort_no_done", 32'(frame_done), 32'd0);
                    ended = 1'b1;
                end else if (mode == 3 && k == 5) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_valid", 32'(tx_if.spi_tx_valid), 32'd0);
                    check("rst_byte", 32'(tx_if.spi_tx_byte), 32'd0);
                    check("rst_num", 32'(tx_if.spi_tx_byte_num), 32'd0);
                    check("rst_busy", 32'(frame_busy), 32'd0);
                    check("rst_done", 32'(frame_done), 32'd0);
                    @(negedge sysClk);
                    rst_n = 1'b1;
                    exp_seq = 0;
                    ended = 1'b1;
                end else begin
                    if (mode == 2 && k == 2) begin
                        randomize_status();
                        frame_start = 1'b1;
                    end else begin
                        frame_start = 1'b0;
                    end
                    if (stall_left > 0) begin
                        tx_if.spi_tx_ready = 1'b0;
                        stall_left--;
                    end else begin
                        tx_if.spi_tx_ready = 1'b1;
                        k++;
                        stall_left = (stall == 0) ? 0 : $urandom_range(0, stall);
                    end
                end
            end
        end
        frame_start = chain_out ? frame_start : 1'b0;
    endtask

    initial begin
        tx_if.spi_tx_ready = 1'b0;
        #1;
        check("reset_valid", 32'(tx_if.spi_tx_valid), 32'd0);
        check("reset_byte", 32'(tx_if.spi_tx_byte), 32'd0);
        check("reset_num", 32'(tx_if.spi_tx_byte_num), 32'd0);
        check("reset_busy", 32'(frame_busy), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        repeat (3) @(negedge sysClk);
        rst_n = 1'b1;
        @(negedge sysClk);

        send_frame(1'b0, 1'b0, 0, 0, 1'b1);
        for (int f = 0; f < 4; f++) send_frame(1'b0, 1'b0, 3, 0, 1'b0);

        send_frame(1'b0, 1'b0, 1, 1, 1'b0);
        send_frame(1'b0, 1'b0, 1, 0, 1'b0);

        send_frame(1'b0, 1'b0, 2, 2, 1'b0);

        for (int f = 0; f < 17; f++) send_frame(f != 0, f != 16, 1, 0, 1'b0);

        send_frame(1'b0, 1'b0, 0, 3, 1'b0);
        send_frame(1'b0, 1'b0, 2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
